// File: rtl/count_step_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// count_step_controller: debounced push-switch stepper with auto-repeat that
// drives a 4-digit BCD count with leading-zero blanking.   Rev 1.0
// ============================================================================
module count_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 5,
  parameter bit          WRAP            = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_in,
  input  logic        dir,
  input  logic        clear,
  output logic [15:0] bcd,
  output logic [3:0]  blank,
  output logic        step_pulse,
  output logic        at_limit
);

  localparam logic [23:0] DEB_LAST    = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic        sync1_q, sync2_q;
  logic        deb_q, deb_d;
  logic [23:0] deb_cnt_q, deb_cnt_d;
  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic        step_go;
  logic [15:0] bcd_q, bcd_d, bcd_next;
  logic [3:0]  blank_q, blank_d;
  logic        step_pulse_q, step_pulse_d;
  logic        carry;

  // Debounce: count consecutive samples that disagree with the accepted state.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 24'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (deb_q) begin
          step_go = 1'b1;
          timer_d = '0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (!deb_q) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (timer_q == DELAY_LAST) begin
          step_go = 1'b1;
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      REPEAT: begin
        if (!deb_q) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (timer_q == PERIOD_LAST) begin
          step_go = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Ripple carry/borrow across the digits; a carry out of the top digit
  // means the count rolled past 9999 or below 0.
  always_comb begin
    bcd_next = bcd_q;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dir) begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            bcd_next[4*i +: 4] = 4'd0;
          end else begin
            bcd_next[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            bcd_next[4*i +: 4] = 4'd9;
          end else begin
            bcd_next[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
    if (carry && !WRAP) begin
      bcd_next = bcd_q;
    end
  end

  always_comb begin
    bcd_d        = bcd_q;
    step_pulse_d = 1'b0;
    if (clear) begin
      bcd_d = '0;
    end else if (step_go) begin
      bcd_d        = bcd_next;
      step_pulse_d = 1'b1;
    end
    blank_d[3] = (bcd_d[15:12] == 4'd0);
    blank_d[2] = blank_d[3] && (bcd_d[11:8] == 4'd0);
    blank_d[1] = blank_d[2] && (bcd_d[7:4] == 4'd0);
    blank_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      deb_q        <= 1'b0;
      deb_cnt_q    <= '0;
      state_q      <= IDLE;
      timer_q      <= '0;
      bcd_q        <= '0;
      blank_q      <= 4'b1110;
      step_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= sw_in;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bcd_q        <= bcd_d;
      blank_q      <= blank_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign bcd        = bcd_q;
  assign blank      = blank_q;
  assign step_pulse = step_pulse_q;
  assign at_limit   = dir ? (bcd_q == 16'h9999) : (bcd_q == 16'h0000);

endmodule
`default_nettype wire

// File: tb/tb_count_step_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_count_step_controller: scoreboard bench comparing a wrapping and a
// saturating instance against an integer-count reference model.   Rev 1.0
// ============================================================================
module tb_count_step_controller;

  localparam int DEB    = 4;
  localparam int RDELAY = 20;
  localparam int RPER   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sw_in = 1'b0;
  logic        dir = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] bcd_w, bcd_s;
  logic [3:0]  blank_w, blank_s;
  logic        pulse_w, pulse_s, lim_w, lim_s;

  count_step_controller #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDELAY),
                          .REPEAT_PERIOD(RPER), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .sw_in(sw_in), .dir(dir), .clear(clear),
    .bcd(bcd_w), .blank(blank_w), .step_pulse(pulse_w), .at_limit(lim_w));

  count_step_controller #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDELAY),
                          .REPEAT_PERIOD(RPER), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .sw_in(sw_in), .dir(dir), .clear(clear),
    .bcd(bcd_s), .blank(blank_s), .step_pulse(pulse_s), .at_limit(lim_s));

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cw;
    int cs;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          pulse_cycs[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [15:0] pre_bcd;
  logic [3:0]  pre_blank;

  // reference model state: plain integers, not the RTL's encoding
  int m_s1, m_s2, m_deb, m_run, m_hold, m_age, m_cw, m_cs, m_step;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int blank_of(input int v);
    return ((v < 1000) ? 8 : 0) | ((v < 100) ? 4 : 0) | ((v < 10) ? 2 : 0);
  endfunction

  function automatic int step_val(input int v, input bit up, input bit wrap);
    if (up) return (v == 9999) ? (wrap ? 0 : 9999) : v + 1;
    else    return (v == 0)    ? (wrap ? 9999 : 0) : v - 1;
  endfunction

  task automatic model_edge();
    cyc++;
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0;
      m_hold = 0; m_age = 0; m_cw = 0; m_cs = 0;
    end else begin
      m_step = 0;
      if (m_hold != 0) begin
        if (m_deb == 0) m_hold = 0;
        else begin
          m_age++;
          if (m_age == RDELAY || (m_age > RDELAY && (m_age - RDELAY) % RPER == 0))
            m_step = 1;
        end
      end else if (m_deb != 0) begin
        m_hold = 1;
        m_age  = 0;
        m_step = 1;
      end
      if (clear) begin
        m_cw = 0;
        m_cs = 0;
      end else if (m_step != 0) begin
        m_cw = step_val(m_cw, dir, 1'b1);
        m_cs = step_val(m_cs, dir, 1'b0);
        exp_q.push_back('{cyc: cyc, cw: m_cw, cs: m_cs});
      end
      // accepted once the synchronised sample has disagreed DEB times in a row
      if (m_s2 == m_deb) m_run = 0;
      else begin
        m_run++;
        if (m_run == DEB) begin
          m_deb = m_s2;
          m_run = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = int'(sw_in);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // monitor
  initial forever begin
    @(negedge clk);
    if (rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("step_missed_at_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (pulse_w) pulse_cycs.push_back(cyc);
      if (pulse_w || pulse_s || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          chk("step_pulse", {pulse_w, pulse_s}, 3);
          chk("bcd_wrap", bcd_w, to_bcd(e.cw));
          chk("blank_wrap", blank_w, blank_of(e.cw));
          chk("bcd_sat", bcd_s, to_bcd(e.cs));
          chk("blank_sat", blank_s, blank_of(e.cs));
          chk("at_limit_wrap", lim_w, dir ? int'(e.cw == 9999) : int'(e.cw == 0));
          chk("at_limit_sat", lim_s, dir ? int'(e.cs == 9999) : int'(e.cs == 0));
        end else begin
          chk("unexpected_step_pulse", {pulse_w, pulse_s}, 0);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int n);
    sw_in = 1'b1;
    cycles(n);
    sw_in = 1'b0;
  endtask

  task automatic preload(input int v);
    @(negedge clk);
    #1;
    pre_bcd   = 16'(to_bcd(v));
    pre_blank = 4'(blank_of(v));
    force u_wrap.bcd_q   = pre_bcd;
    force u_sat.bcd_q    = pre_bcd;
    force u_wrap.blank_q = pre_blank;
    force u_sat.blank_q  = pre_blank;
    #1;
    release u_wrap.bcd_q;
    release u_sat.bcd_q;
    release u_wrap.blank_q;
    release u_sat.blank_q;
    m_cw = v;
    m_cs = v;
    cycles(1);
  endtask

  int rise, p2, t, hold_left;

  initial begin
    cycles(3);
    chk("reset_bcd", bcd_w, 0);
    chk("reset_blank", blank_w, 4'b1110);
    chk("reset_step_pulse", pulse_w, 0);
    chk("reset_at_limit_up", lim_w, 0);
    dir = 1'b0;
    #1;
    chk("reset_at_limit_down", lim_w, 1);
    dir = 1'b1;
    rst = 1'b1;

    // short glitch is ignored
    press(3);
    cycles(15);
    chk("glitch_bcd", bcd_w, 0);
    chk("glitch_blank", blank_w, 4'b1110);
    chk("glitch_no_steps", pulse_cycs.size(), 0);

    // single press: one step, 7 cycles after the raw edge
    rise = cyc;
    press(10);
    cycles(20);
    chk("single_steps", pulse_cycs.size(), 1);
    if (pulse_cycs.size() > 0) chk("single_latency", pulse_cycs[0] - rise, 7);
    chk("single_bcd", bcd_w, 16'h0001);

    // held switch: auto-repeat cadence
    pulse_cycs.delete();
    rise = cyc;
    press(38);
    cycles(30);
    chk("hold_steps", pulse_cycs.size(), 5);
    if (pulse_cycs.size() >= 3) begin
      chk("hold_first_latency", pulse_cycs[0] - rise, 7);
      chk("hold_delay_gap", pulse_cycs[1] - pulse_cycs[0], RDELAY);
      chk("hold_period_gap", pulse_cycs[2] - pulse_cycs[1], RPER);
    end
    chk("hold_bcd", bcd_w, 16'h0006);

    // 9999 up: wrap vs saturate
    preload(9999);
    dir = 1'b1;
    press(10);
    cycles(20);
    chk("wrap_up_bcd", bcd_w, 16'h0000);
    chk("wrap_up_blank", blank_w, 4'b1110);
    chk("sat_up_bcd", bcd_s, 16'h9999);
    chk("sat_up_at_limit", lim_s, 1);

    // borrow across digits, then 0 down
    preload(1000);
    dir = 1'b0;
    press(10);
    cycles(20);
    chk("borrow_bcd", bcd_w, 16'h0999);
    chk("borrow_blank", blank_w, 4'b1000);
    preload(0);
    press(10);
    cycles(20);
    chk("wrap_down_bcd", bcd_w, 16'h9999);
    chk("sat_down_bcd", bcd_s, 16'h0000);

    // clear in the cycle a repeat step is due
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    dir = 1'b1;
    pulse_cycs.delete();
    sw_in = 1'b1;
    t = 0;
    while (pulse_cycs.size() < 2 && t < 200) begin
      cycles(1);
      t++;
    end
    chk("repeat_step_seen", int'(pulse_cycs.size() >= 2), 1);
    if (pulse_cycs.size() >= 2) begin
      p2 = pulse_cycs[1];
      while (cyc < p2 + RPER - 1) cycles(1);
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      chk("clear_step_pulse", pulse_w, 0);
      chk("clear_bcd", bcd_w, 0);
      cycles(RPER);
      chk("after_clear_bcd", bcd_w, 16'h0001);
      chk("after_clear_pulse", pulse_w, 1);
    end

    // reset mid-hold
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midhold_reset_bcd", bcd_w, 0);
    chk("midhold_reset_blank", blank_w, 4'b1110);
    chk("midhold_reset_pulse", pulse_w, 0);
    cycles(2);
    rst = 1'b1;
    cycles(15);
    chk("post_reset_bcd", bcd_w, 16'h0001);
    sw_in = 1'b0;
    cycles(15);

    // randomized traffic near the top boundary
    preload(9995);
    hold_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_left == 0) begin
        sw_in = ~sw_in;
        hold_left = sw_in ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 12));
      end
      hold_left--;
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      clear = ($urandom_range(0, 59) == 0);
      cycles(1);
    end
    sw_in = 1'b0;
    clear = 1'b0;
    cycles(30);
    chk("final_bcd_wrap", bcd_w, to_bcd(m_cw));
    chk("final_bcd_sat", bcd_s, to_bcd(m_cs));
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
